jtag_dtm_gen: RTL and testbench
===============================

# jtag_dtm_gen

Parametrised next-generation JTAG Debug Transport Module. It sits between the TAP controller (capture/shift/update strobes, current IR) and the RISC-V Debug Module, serving IDCODE, DTMCS, DMI and BYPASS data registers. It adds a split request/response DMI handshake with an outstanding-operation FSM, sticky busy/error status per Debug Spec 0.13.2, and `dmireset`/`dtmhardreset` handling.

## Interface
Parameters:
- `ABITS`, 7: DMI address width, 1..32; DMI DR length = `ABITS`+34.
- `IDCODE_VALUE`, 32'h1DEAD3FF: IDCODE capture value; bit 0 must be 1.
- `IDLE_CYCLES`, 1: value reported in DTMCS.idle, 0..7.

Ports:
- `clk` in 1: single clock, TAP strobes synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out, combinational from selected register bit 0.
- `capture_dr`, `shift_dr`, `update_dr` in 1 each: one-cycle TAP strobes.
- `ir_out` in 5: current instruction. 01 IDCODE, 10 DTMCS, 11 DMI, 1F and all other codes BYPASS.
- `dmi_req_valid` out 1: request valid.
- `dmi_req_ready` in 1: DM accepts request.
- `dmi_req_addr` out `ABITS`: request address.
- `dmi_req_data` out 32: write data.
- `dmi_req_op` out 2: 1 read, 2 write.
- `dmi_rsp_valid` in 1: response valid. The DTM is always ready while waiting.
- `dmi_rsp_data` in 32: read data.
- `dmi_rsp_resp` in 2: 0 success, 2 failed, 3 busy.
- `idcode` out 32: constant `IDCODE_VALUE`.

## Operation
- The shift register is shared and sized `ABITS`+34. The active length depends on IR: 32 for IDCODE/DTMCS, `ABITS`+34 for DMI, 1 for BYPASS.
- Shift: shift right within the active length; `tdi` enters the MSB of the active length.
- Capture values:
  - IDCODE: `IDCODE_VALUE`.
  - BYPASS: 0.
  - DTMCS: {14'b0, 0, 0, 1'b0, `IDLE_CYCLES`[2:0], dmistat[1:0], `ABITS`[5:0], 4'h1}.
  - DMI: {last_addr, rsp_data_q, op_field}. op_field is 3 if FSM ≠ IDLE or sticky = 3; otherwise it is the sticky value (0 or 2).
- Sticky status `dmistat` (2 bits):
  - Set to 3 when DMI capture_dr or update_dr occurs while FSM ≠ IDLE.
  - Set to 2 on a response with resp = 2 if currently 0.
  - A response with resp = 3 sets it to 3.
  - Never cleared except by `dmireset`, `dtmhardreset` or reset.
- DMI update: with FSM IDLE, sticky = 0 and op ∈ {1, 2}:
  - Latch addr/data/op.
  - FSM → REQ.
  - last_addr ← addr.
  - Otherwise ignore; op 0 (nop) and 3 are always ignored.
- FSM:
  - IDLE → REQ on an accepted update.
  - REQ holds `dmi_req_valid` = 1 with stable payload until `dmi_req_ready`, then → WAIT.
  - WAIT on `dmi_rsp_valid`: rsp_data_q ← `dmi_rsp_data` (writes included); status update as above; → IDLE.
- DTMCS update:
  - Shifted bit 16 (`dmireset`): clear sticky to 0.
  - Shifted bit 17 (`dtmhardreset`): clear sticky; FSM → IDLE immediately, dropping `dmi_req_valid`; a later `dmi_rsp_valid` in IDLE is ignored.
  - Other bits are ignored.
- Simultaneous response arrival and DMI capture in the same cycle: the capture reports busy (3) and sets sticky. The response data is still latched.

## Timing
- Reset values:
  - `tdo` reflects shift reg bit 0 = 0.
  - `dmi_req_valid` 0; `dmi_req_addr`/`dmi_req_data`/`dmi_req_op` 0.
  - FSM IDLE; sticky 0; rsp_data_q 0; last_addr 0.
  - `idcode` is constant.
- `dmi_req_valid` rises on the cycle after `update_dr`. The minimum request is 1 cycle when `dmi_req_ready` is already high.
- WAIT → IDLE occurs on the cycle after `dmi_rsp_valid`. A capture in that next cycle sees IDLE.
- A response arriving in the same cycle as ready (REQ state) is ignored; the DM must respond ≥1 cycle after accept.
- `rst_n` assertion mid-operation aborts asynchronously to the reset values; the DM must tolerate a dropped request.
- `tdo` changes the cycle after each shift/capture strobe.

## Test plan
- Reset, IR=01, capture + 32 shifts → `tdo` serialises 0x1DEAD3FF LSB-first. IR=1F, shift 8'hA5 → output is 0 then A5 delayed by 1.
- DTMCS capture with `ABITS`=7, `IDLE_CYCLES`=1 → 0x00001071.
- DMI write addr 0x10, data 0x1, `dmi_req_ready` high after 3 cycles, response success 2 cycles later → payload stable throughout. Next capture returns addr 0x10, op 0.
- DMI read with `dmi_rsp_data`=0xDEADBEEF; capture after completion → data field 0xDEADBEEF, op 0.
- DMI capture while WAIT → op 3. The following update (read 0x11) produces no request. DTMCS.dmistat = 3. DTMCS update with bit16=1 → dmistat 0, and the next DMI op issues.
- Issue a request, hold `dmi_req_ready` low, then DTMCS update with bit17=1 → `dmi_req_valid` falls the next cycle, a stray response is ignored, and the next read issues normally. Also repeat with `ABITS`=9: DMI chain length is 43.

Source files
------------

// File: rtl/jtag_dtm_gen.sv
// JTAG Debug Transport Module: IDCODE/DTMCS/DMI/BYPASS data registers in front of a
// split request/response DMI port, with sticky busy/error status and dmireset/dtmhardreset.
module jtag_dtm_gen #(
    parameter int unsigned ABITS        = 7,
    parameter logic [31:0] IDCODE_VALUE = 32'h1DEAD3FF,
    parameter int unsigned IDLE_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tdi,
    output logic             tdo,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic [4:0]       ir_out,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_resp,
    output logic [31:0]      idcode
);

    localparam int unsigned DRW         = ABITS + 34;
    localparam int unsigned IDW         = 32;
    localparam logic [4:0]  IR_IDCODE   = 5'h01;
    localparam logic [4:0]  IR_DTMCS    = 5'h10;
    localparam logic [4:0]  IR_DMI      = 5'h11;
    localparam logic [1:0]  OP_READ     = 2'd1;
    localparam logic [1:0]  OP_WRITE    = 2'd2;
    localparam logic [1:0]  RESP_FAILED = 2'd2;
    localparam logic [1:0]  RESP_BUSY   = 2'd3;
    localparam logic [1:0]  STAT_OK     = 2'd0;
    localparam logic [1:0]  STAT_FAILED = 2'd2;
    localparam logic [1:0]  STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DRW-1:0]   sr_q, sr_d;
    logic [DRW-1:0]   sr_shr;
    logic [1:0]       dmistat_q, dmistat_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [ABITS-1:0] last_addr_q, last_addr_d;
    logic             req_valid_q, req_valid_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_op_q, req_op_d;

    logic             sel_idcode, sel_dtmcs, sel_dmi;
    logic             dmi_cap, dmi_upd, dtmcs_upd, upd_accept;
    int unsigned      act_len;
    logic [1:0]       op_field;
    logic [31:0]      dtmcs_val;
    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;

    // IR decode and active DR length
    always_comb begin
        sel_idcode = (ir_out == IR_IDCODE);
        sel_dtmcs  = (ir_out == IR_DTMCS);
        sel_dmi    = (ir_out == IR_DMI);
        act_len    = 1;
        if (sel_idcode || sel_dtmcs) begin
            act_len = IDW;
        end else if (sel_dmi) begin
            act_len = DRW;
        end
    end

    assign dmi_cap    = capture_dr && sel_dmi;
    assign dmi_upd    = update_dr && sel_dmi;
    assign dtmcs_upd  = update_dr && sel_dtmcs;
    assign upd_op     = sr_q[1:0];
    assign upd_data   = sr_q[33:2];
    assign upd_addr   = sr_q[DRW-1:34];
    assign upd_accept = dmi_upd && (dmistat_q == STAT_OK) &&
                        ((upd_op == OP_READ) || (upd_op == OP_WRITE));
    assign sr_shr     = {1'b0, sr_q[DRW-1:1]};

    // A busy FSM or sticky busy both report busy to the debugger
    assign op_field  = ((state_q != ST_IDLE) || (dmistat_q == STAT_BUSY)) ? STAT_BUSY : dmistat_q;
    assign dtmcs_val = {17'b0, 3'(IDLE_CYCLES), dmistat_q, 6'(ABITS), 4'h1};

    // Shared capture/shift register
    always_comb begin
        sr_d = sr_q;
        if (capture_dr) begin
            if (sel_idcode) begin
                sr_d = DRW'(IDCODE_VALUE);
            end else if (sel_dtmcs) begin
                sr_d = DRW'(dtmcs_val);
            end else if (sel_dmi) begin
                sr_d = {last_addr_q, rsp_data_q, op_field};
            end else begin
                sr_d = '0;
            end
        end else if (shift_dr) begin
            for (int unsigned i = 0; i < DRW; i++) begin
                if (i + 1 == act_len) begin
                    sr_d[i] = tdi;
                end else if (i + 1 < act_len) begin
                    sr_d[i] = sr_shr[i];
                end
            end
        end
    end

    // Outstanding-operation FSM and sticky status
    always_comb begin
        state_d     = state_q;
        dmistat_d   = dmistat_q;
        rsp_data_d  = rsp_data_q;
        last_addr_d = last_addr_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;

        case (state_q)
            ST_IDLE: begin
                if (upd_accept) begin
                    state_d     = ST_REQ;
                    req_addr_d  = upd_addr;
                    req_data_d  = upd_data;
                    req_op_d    = upd_op;
                    last_addr_d = upd_addr;
                end
            end
            ST_REQ: begin
                if (dmi_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmi_rsp_valid) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = dmi_rsp_data;
                    if (dmi_rsp_resp == RESP_BUSY) begin
                        dmistat_d = STAT_BUSY;
                    end else if ((dmi_rsp_resp == RESP_FAILED) && (dmistat_q == STAT_OK)) begin
                        dmistat_d = STAT_FAILED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((dmi_cap || dmi_upd) && (state_q != ST_IDLE)) begin
            dmistat_d = STAT_BUSY;
        end
        // dtmhardreset abandons any outstanding operation
        if (dtmcs_upd && (sr_q[16] || sr_q[17])) begin
            dmistat_d = STAT_OK;
        end
        if (dtmcs_upd && sr_q[17]) begin
            state_d = ST_IDLE;
        end

        req_valid_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            dmistat_q   <= STAT_OK;
            rsp_data_q  <= '0;
            last_addr_q <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            dmistat_q   <= dmistat_d;
            rsp_data_q  <= rsp_data_d;
            last_addr_q <= last_addr_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
        end
    end

    assign tdo           = sr_q[0];
    assign dmi_req_valid = req_valid_q;
    assign dmi_req_addr  = req_addr_q;
    assign dmi_req_data  = req_data_q;
    assign dmi_req_op    = req_op_q;
    assign idcode        = IDCODE_VALUE;

endmodule

// File: tb/tb_jtag_dtm_gen.sv
// Bench for jtag_dtm_gen: DR scans and DMI traffic against a transaction-level model,
// with a second instance for the wider DMI address.
`timescale 1ns/1ps
module tb_jtag_dtm_gen;
    localparam int unsigned ABITS_A   = 7;
    localparam int unsigned ABITS_B   = 9;
    localparam logic [31:0] ID_VAL    = 32'h1DEAD3FF;
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_DTMCS  = 5'h10;
    localparam logic [4:0]  IR_DMI    = 5'h11;
    localparam logic [4:0]  IR_BYPASS = 5'h1F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, tdi, capture_dr, shift_dr, update_dr, sel;
    logic [4:0] ir;
    logic dm_ready, dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic [1:0] dm_rsp_resp;

    logic tdo_a, tdo_b, valid_a, valid_b;
    logic [ABITS_A-1:0] addr_a;
    logic [ABITS_B-1:0] addr_b;
    logic [31:0] data_a, data_b, idcode_a, idcode_b;
    logic [1:0] op_a, op_b;

    logic o_tdo, o_valid;
    logic [31:0] o_addr, o_data, o_idcode;
    logic [1:0] o_op;
    assign o_tdo    = sel ? tdo_b : tdo_a;
    assign o_valid  = sel ? valid_b : valid_a;
    assign o_addr   = sel ? 32'(addr_b) : 32'(addr_a);
    assign o_data   = sel ? data_b : data_a;
    assign o_op     = sel ? op_b : op_a;
    assign o_idcode = sel ? idcode_b : idcode_a;

    jtag_dtm_gen #(.ABITS(ABITS_A), .IDCODE_VALUE(ID_VAL), .IDLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tdi(tdi), .tdo(tdo_a),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .ir_out(ir),
        .dmi_req_valid(valid_a), .dmi_req_ready(dm_ready & ~sel),
        .dmi_req_addr(addr_a), .dmi_req_data(data_a), .dmi_req_op(op_a),
        .dmi_rsp_valid(dm_rsp_valid & ~sel), .dmi_rsp_data(dm_rsp_data),
        .dmi_rsp_resp(dm_rsp_resp), .idcode(idcode_a)
    );

    jtag_dtm_gen #(.ABITS(ABITS_B), .IDCODE_VALUE(ID_VAL), .IDLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tdi(tdi), .tdo(tdo_b),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .ir_out(ir),
        .dmi_req_valid(valid_b), .dmi_req_ready(dm_ready & sel),
        .dmi_req_addr(addr_b), .dmi_req_data(data_b), .dmi_req_op(op_b),
        .dmi_rsp_valid(dm_rsp_valid & sel), .dmi_rsp_data(dm_rsp_data),
        .dmi_rsp_resp(dm_rsp_resp), .idcode(idcode_b)
    );

    int n_cmp;
    int n_err;

    // Transaction-level model: phase 0 no op, 1 request offered, 2 awaiting response
    int unsigned cur_abits;
    int          m_phase;
    logic [1:0]  m_sticky;
    logic [31:0] m_last_addr, m_rsp, e_addr, e_data;
    logic [1:0]  e_op;
    bit          rsp_at_cap;
    logic [31:0] cap_rsp_data;
    logic [1:0]  cap_rsp_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] amask();
        return (32'd1 << cur_abits) - 32'd1;
    endfunction

    function automatic logic [63:0] pack_req(input logic v, input logic [31:0] a,
                                             input logic [31:0] d, input logic [1:0] o);
        return (64'(v) << 48) | (64'(a) << 34) | (64'(d) << 2) | 64'(o);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sticky = 2'd0; m_last_addr = '0; m_rsp = '0;
    endtask

    task automatic scan(input logic [4:0] irv, input int len, input logic [63:0] din,
                        output logic [63:0] dout);
        ir = irv;
        capture_dr = 1'b1;
        if (rsp_at_cap) begin
            dm_rsp_valid = 1'b1; dm_rsp_data = cap_rsp_data; dm_rsp_resp = cap_rsp_resp;
        end
        tick();
        capture_dr = 1'b0;
        dm_rsp_valid = 1'b0;
        dout = '0;
        for (int i = 0; i < len; i++) begin
            tdi = din[i];
            dout[i] = o_tdo;
            shift_dr = 1'b1;
            tick();
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic dmi_scan(input logic [1:0] op, input logic [31:0] addr_in,
                            input logic [31:0] data, output bit acc);
        logic [63:0] din, dout, exp;
        logic [1:0]  opf;
        logic [31:0] addr;
        addr = addr_in & amask();
        opf = (m_phase != 0 || m_sticky == 2'd3) ? 2'd3 : m_sticky;
        exp = (64'(m_last_addr) << 34) | (64'(m_rsp) << 2) | 64'(opf);
        if (m_phase != 0) m_sticky = 2'd3;
        if (rsp_at_cap) begin
            m_rsp = cap_rsp_data;
            m_phase = 0;
        end
        din = (64'(addr) << 34) | (64'(data) << 2) | 64'(op);
        scan(IR_DMI, int'(cur_abits) + 34, din, dout);
        check("dmi_capture", dout, exp);
        acc = 1'b0;
        if (m_phase != 0) begin
            m_sticky = 2'd3;
        end else if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            acc = 1'b1; m_phase = 1; m_last_addr = addr;
            e_addr = addr; e_data = data; e_op = op;
        end
        check("req_valid_after_update", 64'(o_valid), 64'(m_phase == 1));
    endtask

    task automatic dtmcs_scan(input logic [31:0] din);
        logic [63:0] dout;
        logic [31:0] exp;
        exp = 32'h0000_1001 | (32'(m_sticky) << 10) | (cur_abits << 4);
        scan(IR_DTMCS, 32, 64'(din), dout);
        check("dtmcs_capture", dout, 64'(exp));
        if (din[16] || din[17]) m_sticky = 2'd0;
        if (din[17]) m_phase = 0;
    endtask

    task automatic dm_accept(input int dly);
        for (int i = 0; i <= dly; i++) begin
            check("req_payload", pack_req(o_valid, o_addr, o_data, o_op),
                  pack_req(1'b1, e_addr, e_data, e_op));
            if (i == dly) dm_ready = 1'b1;
            tick();
        end
        dm_ready = 1'b0;
        m_phase = 2;
        check("req_valid_after_accept", 64'(o_valid), 64'd0);
    endtask

    task automatic dm_respond(input int dly, input logic [31:0] d, input logic [1:0] r);
        for (int i = 0; i < dly; i++) tick();
        dm_rsp_valid = 1'b1; dm_rsp_data = d; dm_rsp_resp = r;
        tick();
        dm_rsp_valid = 1'b0;
        if (m_phase == 2) begin
            m_rsp = d;
            if (r == 2'd3) m_sticky = 2'd3;
            else if (r == 2'd2 && m_sticky == 2'd0) m_sticky = 2'd2;
            m_phase = 0;
        end
    endtask

    task automatic idcode_check();
        logic [63:0] dout;
        scan(IR_IDCODE, 32, 64'($urandom), dout);
        check("idcode_scan", dout, 64'(ID_VAL));
    endtask

    task automatic bypass_check(input logic [4:0] irv, input logic [7:0] pat);
        logic [63:0] dout;
        scan(irv, 8, 64'(pat), dout);
        check("bypass_scan", dout, 64'({pat[6:0], 1'b0}));
    endtask

    task automatic rand_step();
        int unsigned r, where, rr;
        bit acc, acc2;
        logic [1:0] op;
        logic [4:0] irv;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            op = (r < 4) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
            dmi_scan(op, $urandom, $urandom, acc);
            if (acc) begin
                where = $urandom_range(0, 5);
                if (where == 0) dmi_scan(2'($urandom_range(0, 3)), $urandom, $urandom, acc2);
                dm_accept(int'($urandom_range(0, 3)));
                if (where == 1) dmi_scan(2'($urandom_range(0, 3)), $urandom, $urandom, acc2);
                rr = $urandom_range(0, 3);
                dm_respond(int'($urandom_range(0, 3)), $urandom, (rr == 1) ? 2'd0 : 2'(rr));
            end
        end else if (r < 8) begin
            dtmcs_scan($urandom);
        end else if (r == 8) begin
            idcode_check();
        end else begin
            irv = 5'($urandom);
            if (irv == IR_IDCODE || irv == IR_DTMCS || irv == IR_DMI) irv = IR_BYPASS;
            bypass_check(irv, 8'($urandom));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        n_cmp = 0; n_err = 0;
        sel = 1'b0; cur_abits = ABITS_A;
        tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; ir = IR_BYPASS;
        dm_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_data = '0; dm_rsp_resp = '0;
        rsp_at_cap = 1'b0; cap_rsp_data = '0; cap_rsp_resp = '0;
        e_addr = '0; e_data = '0; e_op = '0;
        model_reset();

        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #12;
        check("reset_tdo", 64'(o_tdo), 64'd0);
        check("reset_req", pack_req(o_valid, o_addr, o_data, o_op), 64'd0);
        check("idcode_port", 64'(o_idcode), 64'(ID_VAL));
        @(negedge clk) rst_n = 1'b1;
        tick();

        idcode_check();
        bypass_check(IR_BYPASS, 8'hA5);
        dtmcs_scan(32'h0);

        // write 0x10 <- 1, ready after 3 cycles, success 2 cycles later
        dmi_scan(2'd2, 32'h10, 32'h1, acc);
        dm_accept(3);
        dm_respond(2, 32'h1234_5678, 2'd0);
        dmi_scan(2'd0, 32'h0, 32'h0, acc);

        // read returning DEADBEEF
        dmi_scan(2'd1, 32'h22, 32'h0, acc);
        dm_accept(0);
        dm_respond(1, 32'hDEAD_BEEF, 2'd0);
        dmi_scan(2'd0, 32'h0, 32'h0, acc);

        // capture while waiting -> busy, following read ignored, dmireset recovers
        dmi_scan(2'd1, 32'h05, 32'h0, acc);
        dm_accept(1);
        dmi_scan(2'd1, 32'h11, 32'h0, acc);
        dm_respond(0, 32'hCAFE_0001, 2'd0);
        dtmcs_scan(32'h0);
        dtmcs_scan(32'h0001_0000);
        dmi_scan(2'd1, 32'h11, 32'h0, acc);
        dm_accept(2);
        dm_respond(0, 32'h0BAD_CAFE, 2'd0);

        // response landing in the same cycle as a DMI capture
        dmi_scan(2'd2, 32'h33, 32'h0000_A5A5, acc);
        dm_accept(0);
        rsp_at_cap = 1'b1; cap_rsp_data = 32'h600D_F00D; cap_rsp_resp = 2'd0;
        dmi_scan(2'd0, 32'h0, 32'h0, acc);
        rsp_at_cap = 1'b0;
        dmi_scan(2'd0, 32'h0, 32'h0, acc);
        dtmcs_scan(32'h0001_0000);

        // failed response makes dmistat 2
        dmi_scan(2'd1, 32'h44, 32'h0, acc);
        dm_accept(1);
        dm_respond(1, 32'h5555_AAAA, 2'd2);
        dmi_scan(2'd0, 32'h0, 32'h0, acc);
        dtmcs_scan(32'h0);
        dtmcs_scan(32'h0001_0000);

        repeat (40) rand_step();

        // second instance with 9 address bits; reset lands between clock edges
        sel = 1'b1; cur_abits = ABITS_B;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_req", pack_req(o_valid, o_addr, o_data, o_op), 64'd0);
        check("async_reset_tdo", 64'(o_tdo), 64'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        tick();

        dtmcs_scan(32'h0);
        dmi_scan(2'd2, 32'h1A5, 32'h1357_2468, acc);
        dm_accept(2);
        dm_respond(1, 32'h0, 2'd0);
        dmi_scan(2'd0, 32'h0, 32'h0, acc);

        // dtmhardreset drops a pending request; stray response is ignored
        dmi_scan(2'd1, 32'h155, 32'h0, acc);
        for (int i = 0; i < 3; i++) begin
            check("req_held_no_ready", 64'(o_valid), 64'd1);
            tick();
        end
        dtmcs_scan(32'h0002_0000);
        check("valid_drop_hardreset", 64'(o_valid), 64'd0);
        dm_respond(0, 32'hBAD0_BAD0, 2'd3);
        dmi_scan(2'd1, 32'h0AA, 32'h0, acc);
        dm_accept(1);
        dm_respond(2, 32'h0F0F_0F0F, 2'd0);
        dmi_scan(2'd0, 32'h0, 32'h0, acc);
        dtmcs_scan(32'h0);

        repeat (15) rand_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
